float_divide_iter: RTL
======================

FLOAT_DIVIDE_ITER -- requirements
Module: float_divide_iter

Interface
REQ-001 The block SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 The block SHALL have parameter MAN_W, default 23, stored fraction width; the word width is W = 1+EXP_W+MAN_W.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1, operand pair valid.
REQ-006 The block SHALL have port in_ready, output, 1, block accepts operands.
REQ-007 The block SHALL have ports a and b, input, W each, dividend and divisor in IEEE-style format.
REQ-008 The block SHALL have port out_valid, output, 1, result valid.
REQ-009 The block SHALL have port out_ready, input, 1, consumer accepts result.
REQ-010 The block SHALL have port out, output, W, quotient a/b.
REQ-011 The block SHALL have port flags, output, 5, {invalid, div_by_zero, overflow, underflow, inexact} for the current result.

Function
REQ-012 The FSM SHALL have states IDLE, DIVIDE, ROUND and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-013 Accept SHALL occur when in_valid && in_ready, latching a and b and moving IDLE->DIVIDE, or IDLE->DONE for special operands.
REQ-014 Denormal inputs (exp==0) SHALL be flushed to signed zero before classification.
REQ-015 Special cases SHALL produce out_valid on the cycle after accept:
- NaN operand, 0/0 or inf/inf -> quiet NaN {0, all-ones exp, 1, zeros}, invalid=1.
- finite nonzero/0 -> signed inf, div_by_zero=1.
- inf/finite -> signed inf, no flags.
- 0/nonzero or finite/inf -> signed zero, no flags.
REQ-016 Sign SHALL be a[W-1]^b[W-1] for all results except NaN.
REQ-017 Prenormalisation: with implicit-1 mantissas ma and mb, if ma<mb then ma SHALL be shifted left 1 and the exponent decremented, so that the quotient lies in [1,2).
REQ-018 Exponent SHALL be computed as ea-eb+bias(+prenorm adjust) in a signed EXP_W+2-bit value, where bias=2^(EXP_W-1)-1.
REQ-019 DIVIDE SHALL run a radix-2 restoring divide, one quotient bit per cycle, for exactly MAN_W+3 cycles (integer bit, fraction, guard, round); sticky SHALL be the OR-reduction of the final remainder.
REQ-020 ROUND SHALL apply round-to-nearest-even in one cycle; a mantissa carry-out SHALL increment the exponent; inexact SHALL be set when guard|round|sticky is nonzero.
REQ-021 A final exponent >= all-ones SHALL produce signed inf with overflow=1 and inexact=1.
REQ-022 A final exponent <= 0 SHALL produce signed zero with underflow=1 and inexact=1; no denormal outputs are produced.
REQ-023 Normal-path latency SHALL be MAN_W+5 cycles from the accept edge to out_valid (28 for defaults).
REQ-024 In DONE, out and flags SHALL hold stable while out_ready=0; on out_valid && out_ready the FSM SHALL return to IDLE, and in_ready SHALL rise the next cycle.
REQ-025 in_valid and operand changes outside IDLE SHALL be ignored.

Reset
REQ-026 When reset=1 at a clock edge, the FSM SHALL enter IDLE; out_valid, out and flags SHALL be 0, in_ready SHALL be 1 the following cycle, and any in-flight division SHALL be discarded.
REQ-027 Reset SHALL take priority over accept and over the out handshake in the same cycle.

Structure
REQ-028 Shared package float_pkg SHALL hold the state enum, flag bit indices, default EXP_W/MAN_W, and functions or constants for the bias, quiet NaN and inf encodings.
REQ-029 Sub-module float_unpack (sign, exp, mantissa with implicit 1, is_zero, is_inf, is_nan, denormal flush) SHALL be instantiated once per operand.
REQ-030 The divider datapath SHALL reuse a single subtractor across iterations, with no combinational divide operator.

Verification
REQ-031 a=0x40C00000 (6.0), b=0x40000000 (2.0) -> out=0x40400000 with flags=0, 28 cycles after accept.
REQ-032 a=0x3F800000, b=0x40400000 -> out=0x3EAAAAAB with flags=00001 (inexact).
REQ-033 Check these special operand pairs:
- 0x3F800000/0x00000000 -> 0x7F800000, flags=01000, out_valid 1 cycle after accept.
- 0/0 -> 0x7FC00000, flags=10000.
REQ-034 a=0x7F000000, b=0x3F000000 -> 0x7F800000 with flags=00101; a=0x00800000, b=0x40000000 -> 0x00000000 with flags=00011.
REQ-035 Hold out_ready=0 for 5 cycles in DONE -> out and flags stable and in_ready=0; a new in_valid pulse during that time is ignored.
REQ-036 Assert reset 10 cycles into a DIVIDE -> IDLE on the next edge with out_valid=0, then a fresh 6.0/2.0 completes correctly.

Source files
------------

// File: rtl/float_pkg.sv
// Shared definitions for the iterative floating-point divider: FSM states,
// flag bit positions, default field widths and encoding helpers.
package float_pkg;

    localparam int DEF_EXP_W = 8;
    localparam int DEF_MAN_W = 23;

    // Bit positions inside the 5-bit flags word
    localparam int FLAG_INVALID   = 4;
    localparam int FLAG_DIV_ZERO  = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Exponent bias for an exponent field of exp_w bits
    function automatic int bias_of(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Positive infinity: all-ones exponent, zero fraction (sign bit clear)
    function automatic logic [63:0] inf_bits(input int exp_w, input int man_w);
        return ((64'd1 << exp_w) - 64'd1) << man_w;
    endfunction

    // Quiet NaN: positive, all-ones exponent, fraction MSB set
    function automatic logic [63:0] qnan_bits(input int exp_w, input int man_w);
        return inf_bits(exp_w, man_w) | (64'd1 << (man_w - 1));
    endfunction

endpackage

// File: rtl/float_unpack.sv
// Splits one IEEE-style word into sign, exponent and mantissa with the
// implicit one restored, and classifies it. Denormals are flushed to zero.
module float_unpack
    import float_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
) (
    input  logic [EXP_W+MAN_W:0] x_i,
    output logic                 sign_o,
    output logic [EXP_W-1:0]     exp_o,
    output logic [MAN_W:0]       man_o,
    output logic                 zero_o,
    output logic                 inf_o,
    output logic                 nan_o
);

    logic exp_zero;
    logic exp_ones;
    logic frac_zero;

    assign exp_zero  = (x_i[EXP_W+MAN_W-1:MAN_W] == '0);
    assign exp_ones  = (x_i[EXP_W+MAN_W-1:MAN_W] == '1);
    assign frac_zero = (x_i[MAN_W-1:0] == '0);

    assign sign_o = x_i[EXP_W+MAN_W];
    assign exp_o  = x_i[EXP_W+MAN_W-1:MAN_W];
    // A zero exponent means zero or denormal; both become a plain zero
    assign man_o  = exp_zero ? '0 : {1'b1, x_i[MAN_W-1:0]};
    assign zero_o = exp_zero;
    assign inf_o  = exp_ones & frac_zero;
    assign nan_o  = exp_ones & ~frac_zero;

endmodule

// File: rtl/float_divide_iter.sv
// Iterative floating-point divider: one restoring-division quotient bit per
// cycle, round-to-nearest-even, flush-to-zero on underflow. Special operands
// bypass the datapath and finish on the cycle after accept.
module float_divide_iter
    import float_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out,
    output logic [4:0]           flags
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int CNT_W = $clog2(MAN_W + 4);
    localparam logic [W-1:0] INF_W  = W'(inf_bits(EXP_W, MAN_W));
    localparam logic [W-1:0] QNAN_W = W'(qnan_bits(EXP_W, MAN_W));
    localparam logic signed [EXP_W+1:0] BIAS_S   = (EXP_W+2)'(bias_of(EXP_W));
    localparam logic signed [EXP_W+1:0] EXP_MAX  = (EXP_W+2)'((1 << EXP_W) - 1);
    localparam logic signed [EXP_W+1:0] EXP_ZERO = '0;
    localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(MAN_W + 2);

    // Unpacked operands
    logic             ua_sign, ub_sign, ua_zero, ub_zero, ua_inf, ub_inf, ua_nan, ub_nan;
    logic [EXP_W-1:0] ua_exp, ub_exp;
    logic [MAN_W:0]   ua_man, ub_man;

    float_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
        .x_i(a), .sign_o(ua_sign), .exp_o(ua_exp), .man_o(ua_man),
        .zero_o(ua_zero), .inf_o(ua_inf), .nan_o(ua_nan)
    );

    float_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
        .x_i(b), .sign_o(ub_sign), .exp_o(ub_exp), .man_o(ub_man),
        .zero_o(ub_zero), .inf_o(ub_inf), .nan_o(ub_nan)
    );

    // State and datapath registers
    state_t                  state_q, state_d;
    logic                    sign_q, sign_d;
    logic [MAN_W:0]          mb_q, mb_d;
    logic [MAN_W+1:0]        rem_q, rem_d;
    // Fraction, guard and round bits; the integer bit is always 1 after
    // prenormalisation and simply shifts out of the top.
    logic [MAN_W+1:0]        quo_q, quo_d;
    logic signed [EXP_W+1:0] exp_q, exp_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [W-1:0]            out_q, out_d;
    logic [4:0]              flags_q, flags_d;

    // Combinational helpers
    logic                    in_sign;
    logic                    sp_nan, sp_dbz, sp_inf, sp_zero, special;
    logic                    prenorm;
    logic signed [EXP_W+1:0] exp_pre, exp_fin;
    logic [MAN_W+2:0]        diff;
    logic [MAN_W+1:0]        rem_sel;
    logic                    sticky, round_up, inexact;
    logic [MAN_W:0]          frac_sum;

    // Operand classification, prenormalisation and the shared subtractor
    always_comb begin
        in_sign = ua_sign ^ ub_sign;
        sp_nan  = ua_nan | ub_nan | (ua_zero & ub_zero) | (ua_inf & ub_inf);
        sp_dbz  = ~sp_nan & ub_zero;
        sp_inf  = ~sp_nan & ~ub_zero & ua_inf;
        sp_zero = ~sp_nan & ~ub_zero & ~ua_inf & (ua_zero | ub_inf);
        special = sp_nan | sp_dbz | sp_inf | sp_zero;

        // Doubling the dividend when ma < mb keeps the quotient in [1,2)
        prenorm = (ua_man < ub_man);
        exp_pre = $signed({2'b00, ua_exp}) - $signed({2'b00, ub_exp}) + BIAS_S
                  - $signed({{(EXP_W+1){1'b0}}, prenorm});

        diff    = {1'b0, rem_q} - {2'b00, mb_q};
        rem_sel = diff[MAN_W+2] ? rem_q : diff[MAN_W+1:0];

        sticky   = |rem_q;
        round_up = quo_q[1] & (quo_q[0] | sticky | quo_q[2]);
        inexact  = quo_q[1] | quo_q[0] | sticky;
        frac_sum = {1'b0, quo_q[MAN_W+1:2]} + {{MAN_W{1'b0}}, round_up};
        // Fraction carry-out means the mantissa rounded up to 2.0
        exp_fin  = exp_q + $signed({{(EXP_W+1){1'b0}}, frac_sum[MAN_W]});
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        mb_d    = mb_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        exp_d   = exp_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        flags_d = flags_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    flags_d = '0;
                    if (special) begin
                        state_d = DONE;
                        if (sp_nan) begin
                            out_d                 = QNAN_W;
                            flags_d[FLAG_INVALID] = 1'b1;
                        end else if (sp_dbz || sp_inf) begin
                            out_d                  = {in_sign, INF_W[W-2:0]};
                            flags_d[FLAG_DIV_ZERO] = sp_dbz;
                        end else begin
                            out_d = {in_sign, {(W-1){1'b0}}};
                        end
                    end else begin
                        state_d = DIVIDE;
                        mb_d    = ub_man;
                        rem_d   = prenorm ? {ua_man, 1'b0} : {1'b0, ua_man};
                        quo_d   = '0;
                        exp_d   = exp_pre;
                        cnt_d   = '0;
                    end
                end
            end
            DIVIDE: begin
                quo_d = {quo_q[MAN_W:0], ~diff[MAN_W+2]};
                rem_d = rem_sel << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                state_d = DONE;
                flags_d = '0;
                if (exp_fin >= EXP_MAX) begin
                    out_d                  = {sign_q, INF_W[W-2:0]};
                    flags_d[FLAG_OVERFLOW] = 1'b1;
                    flags_d[FLAG_INEXACT]  = 1'b1;
                end else if (exp_fin <= EXP_ZERO) begin
                    out_d                   = {sign_q, {(W-1){1'b0}}};
                    flags_d[FLAG_UNDERFLOW] = 1'b1;
                    flags_d[FLAG_INEXACT]   = 1'b1;
                end else begin
                    out_d                 = {sign_q, exp_fin[EXP_W-1:0], frac_sum[MAN_W-1:0]};
                    flags_d[FLAG_INEXACT] = inexact;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            mb_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            exp_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            mb_q    <= mb_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            exp_q   <= exp_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            flags_q <= flags_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = out_q;
    assign flags     = flags_q;

endmodule
